// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32I core.
// Captures decoded operands and control from ID for the EX stage, detects
// load-use hazards (one-cycle bubble plus stall), applies branch flushes and
// bypasses same-cycle WB writes into the captured register operands.
// Optional feature macro: ID_EX_STALL_CNT_EN adds a saturating stall counter;
// without it stall_cnt is tied to zero.
module id_ex_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ID_valid,
    input  logic [31:0]      ID_pc,
    input  logic [31:0]      ID_imm,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic [31:0]      ID_RD1,
    input  logic [31:0]      ID_RD2,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_ALUSrc,
    input  logic [4:0]       ID_ALUOp,
    input  logic [1:0]       ID_WDSel,
    input  logic             EX_flush,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_rd,
    input  logic [31:0]      WB_WD,
    output logic             stall,
    output logic             EX_valid,
    output logic [31:0]      EX_pc,
    output logic [31:0]      EX_imm,
    output logic [31:0]      EX_RD1,
    output logic [31:0]      EX_RD2,
    output logic [4:0]       EX_rs1,
    output logic [4:0]       EX_rs2,
    output logic [4:0]       EX_rd,
    output logic             EX_RegWrite,
    output logic             EX_MemRead,
    output logic             EX_MemWrite,
    output logic             EX_ALUSrc,
    output logic [4:0]       EX_ALUOp,
    output logic [1:0]       EX_WDSel,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_regwrite;
    logic        r_memread;
    logic        r_memwrite;
    logic        r_alusrc;
    logic [4:0]  r_aluop;
    logic [1:0]  r_wdsel;

    logic        w_hz;
    logic        w_stall;
    logic        w_byp1;
    logic        w_byp2;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    // Load-use hazard detection and WB-to-ID operand bypass selection.
    always_comb begin
        w_hz    = r_valid & r_memread & (r_rd != 5'd0) & ID_valid &
                  ((ID_uses_rs1 & (ID_rs1 == r_rd)) | (ID_uses_rs2 & (ID_rs2 == r_rd)));
        w_stall = w_hz & ~EX_flush;
        w_byp1  = WB_RegWrite & (WB_rd != 5'd0) & (WB_rd == ID_rs1);
        w_byp2  = WB_RegWrite & (WB_rd != 5'd0) & (WB_rd == ID_rs2);
        if (w_byp1) begin
            w_rd1 = WB_WD;
        end else begin
            w_rd1 = ID_RD1;
        end
        if (w_byp2) begin
            w_rd2 = WB_WD;
        end else begin
            w_rd2 = ID_RD2;
        end
    end

    // Pipeline register: flush or hazard inserts a bubble, otherwise load ID.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_imm      <= 32'd0;
            r_rd1      <= 32'd0;
            r_rd2      <= 32'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 5'd0;
            r_wdsel    <= 2'd0;
        end else if (EX_flush || w_hz) begin
            // Bubble: register indices go to x0 so forwarding sees no match;
            // pc/imm/operands keep their old values.
            r_valid    <= 1'b0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 5'd0;
            r_wdsel    <= 2'd0;
        end else begin
            // An invalid ID slot is loaded but must not write or touch memory.
            r_valid    <= ID_valid;
            r_pc       <= ID_pc;
            r_imm      <= ID_imm;
            r_rd1      <= w_rd1;
            r_rd2      <= w_rd2;
            r_rs1      <= ID_rs1;
            r_rs2      <= ID_rs2;
            r_rd       <= ID_rd;
            r_regwrite <= ID_RegWrite & ID_valid;
            r_memread  <= ID_MemRead & ID_valid;
            r_memwrite <= ID_MemWrite & ID_valid;
            r_alusrc   <= ID_ALUSrc;
            r_aluop    <= ID_ALUOp;
            r_wdsel    <= ID_WDSel;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles in which the front end was frozen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

    assign stall       = w_stall;
    assign EX_valid    = r_valid;
    assign EX_pc       = r_pc;
    assign EX_imm      = r_imm;
    assign EX_RD1      = r_rd1;
    assign EX_RD2      = r_rd2;
    assign EX_rs1      = r_rs1;
    assign EX_rs2      = r_rs2;
    assign EX_rd       = r_rd;
    assign EX_RegWrite = r_regwrite;
    assign EX_MemRead  = r_memread;
    assign EX_MemWrite = r_memwrite;
    assign EX_ALUSrc   = r_alusrc;
    assign EX_ALUOp    = r_aluop;
    assign EX_WDSel    = r_wdsel;

endmodule
